perf_counter_bank: RTL and testbench

- Tile-level bank of six 32-bit performance counters with sticky overflow flags and a CSR read/write port.
- Counters: physical ops, effective ops, SRAM bytes, DRAM bytes, DMA stall cycles, mask stall cycles.
- Consumes per-cycle increment events from the tile datapath and memory interface, and produces the counter values and overflow_flags returned at CSR 0x9C.
- Adds atomic snapshot, clear and freeze so software reads a coherent set of counters.

---
 rtl/perf_ctr_pkg.sv | 16 +
 rtl/perf_ctr_cell.sv | 36 +++
 rtl/perf_counter_bank.sv | 80 ++++++++
 tb/tb_perf_counter_bank.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_ctr_pkg.sv
// perf_ctr_pkg: CSR addresses, ctrl bit indices and counter indices for the perf counter bank
package perf_ctr_pkg;
  localparam logic [7:0] CTR_BASE = 8'h80;
  localparam logic [7:0] CTRL = 8'h98;
  localparam logic [7:0] OVF = 8'h9C;
  localparam logic [7:0] SNAP_BASE = 8'hA0;
  localparam int CTRL_SNAP = 0;
  localparam int CTRL_CLR = 1;
  localparam int CTRL_FREEZE = 2;
  localparam int PHYS_OPS = 0;
  localparam int EFF_OPS = 1;
  localparam int BYTES_SRAM = 2;
  localparam int BYTES_DRAM = 3;
  localparam int DMA_STALL = 4;
  localparam int MASK_STALL = 5;
endpackage

// File: rtl/perf_ctr_cell.sv
// perf_ctr_cell: one wrapping counter with sticky overflow flag and snapshot register
module perf_ctr_cell #(
  parameter int CTR_W = 32,
  parameter int INC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_valid,
  input  logic [INC_W-1:0] inc_amount,
  input  logic             freeze,
  input  logic             load,
  input  logic [CTR_W-1:0] load_data,
  input  logic             clr,
  input  logic             snap,
  input  logic             flag_clr,
  output logic [CTR_W-1:0] value,
  output logic [CTR_W-1:0] snapshot,
  output logic             flag
);
  logic [CTR_W:0] sum;
  logic inc;
  assign sum = {1'b0, value} + (CTR_W+1)'(inc_amount);
  assign inc = inc_valid & ~freeze & ~load & ~clr;
  // write beats clear beats increment; only a surviving increment may raise the flag
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
      snapshot <= '0;
      flag <= 1'b0;
    end else begin
      value <= load ? load_data : clr ? '0 : inc ? sum[CTR_W-1:0] : value;
      flag <= (inc & sum[CTR_W]) | (flag & ~flag_clr);
      if (snap) snapshot <= value;
    end
  end
endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: bank of performance counters with CSR access, snapshot, clear and freeze
module perf_counter_bank
  import perf_ctr_pkg::*;
#(
  parameter int NUM_CTRS = 6,
  parameter int CTR_W = 32,
  parameter int INC_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CTRS-1:0]       inc_valid,
  input  logic [NUM_CTRS*INC_W-1:0] inc_amount,
  input  logic                      freeze_in,
  input  logic                      csr_valid,
  input  logic                      csr_write,
  input  logic [7:0]                csr_addr,
  input  logic [31:0]               csr_wdata,
  output logic [31:0]               csr_rdata,
  output logic                      csr_ready,
  output logic [NUM_CTRS*CTR_W-1:0] ctr_values,
  output logic [7:0]                overflow_flags
);
  logic wr, rd, ctrl_wr, snap, clr, frozen, frz_bit;
  logic [NUM_CTRS-1:0] load, flag_clr, flags;
  logic [CTR_W-1:0] snaps [NUM_CTRS];
  logic [31:0] rd_data;
  assign wr = csr_valid & csr_write;
  assign rd = csr_valid & ~csr_write;
  assign ctrl_wr = wr & (csr_addr == CTRL);
  assign snap = ctrl_wr & csr_wdata[CTRL_SNAP];
  assign clr = ctrl_wr & csr_wdata[CTRL_CLR];
  assign frozen = freeze_in | frz_bit;
  assign overflow_flags = 8'(flags);
  // per-counter CSR write strobes and write-1-to-clear flag strobes
  always_comb begin
    for (int i = 0; i < NUM_CTRS; i++) begin
      load[i] = wr && (csr_addr == CTR_BASE + 8'(4 * i));
      flag_clr[i] = wr && (csr_addr == OVF) && csr_wdata[i];
    end
  end
  // read mux over pre-edge state; unmapped addresses return zero
  always_comb begin
    rd_data = '0;
    if (csr_addr == CTRL) rd_data[CTRL_FREEZE] = frz_bit;
    if (csr_addr == OVF) rd_data[7:0] = overflow_flags;
    for (int i = 0; i < NUM_CTRS; i++) begin
      if (csr_addr == CTR_BASE + 8'(4 * i)) rd_data = 32'(ctr_values[i*CTR_W +: CTR_W]);
      if (csr_addr == SNAP_BASE + 8'(4 * i)) rd_data = 32'(snaps[i]);
    end
  end
  // freeze level, one-cycle response pulse and held read data
  always_ff @(posedge clk) begin
    if (reset) begin
      frz_bit <= 1'b0;
      csr_ready <= 1'b0;
      csr_rdata <= '0;
    end else begin
      csr_ready <= csr_valid;
      if (rd) csr_rdata <= rd_data;
      if (ctrl_wr) frz_bit <= csr_wdata[CTRL_FREEZE];
    end
  end
  for (genvar g = 0; g < NUM_CTRS; g++) begin : g_cell
    perf_ctr_cell #(.CTR_W(CTR_W), .INC_W(INC_W)) u_cell (
      .clk(clk),
      .reset(reset),
      .inc_valid(inc_valid[g]),
      .inc_amount(inc_amount[g*INC_W +: INC_W]),
      .freeze(frozen),
      .load(load[g]),
      .load_data(CTR_W'(csr_wdata)),
      .clr(clr),
      .snap(snap),
      .flag_clr(flag_clr[g]),
      .value(ctr_values[g*CTR_W +: CTR_W]),
      .snapshot(snaps[g]),
      .flag(flags[g])
    );
  end
endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: directed and randomized checks of perf_counter_bank against a behavioural model
module tb_perf_counter_bank;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [5:0] inc_valid = '0;
  logic [95:0] inc_amount = '0;
  logic freeze_in = 1'b0;
  logic csr_valid = 1'b0;
  logic csr_write = 1'b0;
  logic [7:0] csr_addr = '0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] csr_rdata;
  logic csr_ready;
  logic [191:0] ctr_values;
  logic [7:0] overflow_flags;
  longint unsigned m_ctr [6];
  longint unsigned m_snap [6];
  logic [7:0] m_flags;
  bit m_frz, m_ready, m_rd_resp;
  logic [31:0] m_rdata;
  int checks = 0;
  int failures = 0;

  perf_counter_bank dut (
    .clk(clk),
    .reset(reset),
    .inc_valid(inc_valid),
    .inc_amount(inc_amount),
    .freeze_in(freeze_in),
    .csr_valid(csr_valid),
    .csr_write(csr_write),
    .csr_addr(csr_addr),
    .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata),
    .csr_ready(csr_ready),
    .ctr_values(ctr_values),
    .overflow_flags(overflow_flags)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_read(input logic [7:0] a);
    for (int i = 0; i < 6; i++) begin
      if (a == 8'h80 + 8'(4 * i)) return 32'(m_ctr[i]);
      if (a == 8'hA0 + 8'(4 * i)) return 32'(m_snap[i]);
    end
    if (a == 8'h98) return {29'b0, m_frz, 2'b0};
    if (a == 8'h9C) return {24'b0, m_flags};
    return 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    reset = 1'b0;
    inc_valid = '0;
    inc_amount = '0;
    freeze_in = 1'b0;
    csr_valid = 1'b0;
    csr_write = 1'b0;
    csr_addr = '0;
    csr_wdata = '0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    csr_valid = 1'b1;
    csr_write = 1'b1;
    csr_addr = a;
    csr_wdata = d;
  endtask

  task automatic rd(input logic [7:0] a);
    csr_valid = 1'b1;
    csr_write = 1'b0;
    csr_addr = a;
  endtask

  task automatic inc(input int i, input logic [15:0] amt);
    inc_valid[i] = 1'b1;
    inc_amount[i*16 +: 16] = amt;
  endtask

  task automatic check_all();
    chk("ready", {31'b0, csr_ready}, {31'b0, m_ready});
    if (m_ready && m_rd_resp) chk("rdata", csr_rdata, m_rdata);
    for (int i = 0; i < 6; i++) chk($sformatf("ctr%0d", i), ctr_values[i*32 +: 32], 32'(m_ctr[i]));
    chk("flags", {24'b0, overflow_flags}, {24'b0, m_flags});
  endtask

  task automatic cyc();
    logic [7:0] newf;
    bit frz, w, sn, cl;
    longint unsigned s;
    frz = freeze_in | m_frz;
    w = csr_valid & csr_write;
    if (reset) begin
      for (int i = 0; i < 6; i++) begin
        m_ctr[i] = 0;
        m_snap[i] = 0;
      end
      m_flags = 8'h0;
      m_frz = 1'b0;
      m_ready = 1'b0;
      m_rd_resp = 1'b0;
      m_rdata = 32'h0;
    end else begin
      m_ready = csr_valid;
      m_rd_resp = csr_valid & ~csr_write;
      if (m_rd_resp) m_rdata = m_read(csr_addr);
      sn = w && csr_addr == 8'h98 && csr_wdata[0];
      cl = w && csr_addr == 8'h98 && csr_wdata[1];
      newf = m_flags & ~((w && csr_addr == 8'h9C) ? csr_wdata[7:0] : 8'h0);
      for (int i = 0; i < 6; i++) begin
        if (sn) m_snap[i] = m_ctr[i];
        if (w && csr_addr == 8'h80 + 8'(4 * i)) m_ctr[i] = longint'(csr_wdata);
        else if (cl) m_ctr[i] = 0;
        else if (inc_valid[i] && !frz) begin
          s = m_ctr[i] + longint'(inc_amount[i*16 +: 16]);
          if (s >= 64'h1_0000_0000) newf[i] = 1'b1;
          m_ctr[i] = s % 64'h1_0000_0000;
        end
      end
      if (w && csr_addr == 8'h98) m_frz = csr_wdata[2];
      m_flags = newf;
    end
    @(posedge clk);
    #1;
    check_all();
    clr_in();
  endtask

  initial begin
    logic [7:0] a;
    clr_in();
    reset = 1'b1;
    cyc();
    chk("reset_rdata", csr_rdata, 32'h0);
    // wrap on counter 2
    wr(8'h88, 32'hFFFF_FFFF);
    cyc();
    inc(2, 16'd8);
    cyc();
    chk("wrap_val", ctr_values[64 +: 32], 32'h7);
    chk("wrap_flag", {24'b0, overflow_flags}, 32'h04);
    rd(8'h88);
    cyc();
    chk("wrap_rd", csr_rdata, 32'h7);
    rd(8'h9C);
    cyc();
    chk("wrap_rd_ovf", csr_rdata, 32'h04);
    inc(2, 16'd1);
    cyc();
    chk("sticky", {31'b0, overflow_flags[2]}, 32'h1);
    // all counters wrap together
    for (int i = 0; i < 6; i++) begin
      wr(8'h80 + 8'(4 * i), 32'hFFFF_FFFF);
      cyc();
    end
    for (int i = 0; i < 6; i++) inc(i, 16'd1);
    cyc();
    chk("all_flags", {24'b0, overflow_flags}, 32'h3F);
    for (int i = 0; i < 6; i++) chk("all_zero", ctr_values[i*32 +: 32], 32'h0);
    // set wins over W1C
    wr(8'h80, 32'hFFFF_FFFF);
    cyc();
    wr(8'h9C, 32'h01);
    inc(0, 16'd1);
    cyc();
    chk("w1c_set_wins", {24'b0, overflow_flags}, 32'h3F);
    wr(8'h9C, 32'h3F);
    cyc();
    chk("w1c_all", {24'b0, overflow_flags}, 32'h00);
    // snapshot and clear in one write
    for (int i = 0; i < 6; i++) begin
      wr(8'h80 + 8'(4 * i), 32'(5 * (i + 1)));
      cyc();
    end
    wr(8'h98, 32'h3);
    inc(0, 16'd1);
    cyc();
    for (int i = 0; i < 6; i++) chk("clr_zero", ctr_values[i*32 +: 32], 32'h0);
    chk("clr_flags", {24'b0, overflow_flags}, 32'h0);
    for (int i = 0; i < 6; i++) begin
      rd(8'hA0 + 8'(4 * i));
      cyc();
      chk("snap_rd", csr_rdata, 32'(5 * (i + 1)));
    end
    // freeze via ctrl, then via freeze_in
    wr(8'h98, 32'h4);
    cyc();
    rd(8'h98);
    cyc();
    chk("ctrl_rd", csr_rdata, 32'h4);
    repeat (100) begin
      for (int i = 0; i < 6; i++) inc(i, 16'($urandom));
      cyc();
    end
    chk("frozen_ctr0", ctr_values[0 +: 32], 32'h0);
    wr(8'h98, 32'h0);
    cyc();
    freeze_in = 1'b1;
    inc(3, 16'd9);
    cyc();
    chk("freeze_in", ctr_values[96 +: 32], 32'h0);
    wr(8'h84, 32'h10);
    inc(1, 16'hFFFF);
    cyc();
    chk("wr_beats_inc", ctr_values[32 +: 32], 32'h10);
    chk("wr_no_flag", {24'b0, overflow_flags}, 32'h0);
    // back-to-back reads then reset right after a read
    rd(8'h80);
    cyc();
    rd(8'h84);
    cyc();
    chk("b2b_rd84", csr_rdata, 32'h10);
    rd(8'h88);
    cyc();
    rd(8'h98);
    cyc();
    rd(8'h84);
    cyc();
    reset = 1'b1;
    cyc();
    chk("rst_ready", {31'b0, csr_ready}, 32'h0);
    chk("rst_rdata", csr_rdata, 32'h0);
    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 6; i++)
        if ($urandom_range(0, 1) == 1) inc(i, ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom));
      freeze_in = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 1) == 1) begin
        a = 8'h78 + 8'(4 * $urandom_range(0, 17));
        if ($urandom_range(0, 1) == 1) rd(a);
        else if (a == 8'h98) wr(a, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : 32'($urandom_range(0, 3)));
        else wr(a, ($urandom_range(0, 1) == 1) ? 32'hFFFF_FF00 | 32'($urandom_range(0, 255)) : $urandom);
      end
      reset = ($urandom_range(0, 99) == 0);
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
